// File: rtl/mgmt_phy_link_trainer.sv
// Controller-side LTPI link training FSM: walks INIT..OPERATIONAL, negotiates the link speed,
// falls back one speed step per failed hunt, and gives up with a sticky link_fail after repeated loss.
module mgmt_phy_link_trainer #(
  parameter int                 SPEED_W     = 4,
  parameter logic [SPEED_W-1:0] MAX_SPEED   = 4'd7,
  parameter int                 HUNT_TO_CYC = 60000,
  parameter int                 ADV_TO_CYC  = 60000,
  parameter int                 MAX_RETRY   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_end,
  input  logic               aligned,
  input  logic               crc_consec_loss,
  input  logic               unexp_frm_err,
  input  logic               frame_crc_err,
  input  logic               detect_locked,
  input  logic               detect_tx_done,
  input  logic               remote_in_speed,
  input  logic               speed_tx_done,
  input  logic               speed_timeout,
  input  logic [SPEED_W-1:0] remote_speed,
  input  logic               advertise_locked,
  input  logic               auto_move_config,
  input  logic               trigger_config,
  input  logic               cfg_timeout,
  input  logic               accept_rcv,
  input  logic               op_frm_lost,
  input  logic               sw_reset,
  input  logic               remote_sw_reset,
  input  logic               retrain_req,
  input  logic               pll_done,
  output logic               pll_reconfig,
  output logic [SPEED_W-1:0] pll_speed_sel,
  output logic [3:0]         link_state,
  output logic [7:0]         retry_cnt,
  output logic               link_fail,
  output logic               link_up
);

  localparam int MAX_TO = (HUNT_TO_CYC > ADV_TO_CYC) ? HUNT_TO_CYC : ADV_TO_CYC;
  localparam int TMR_W  = $clog2(MAX_TO) + 1;
  localparam logic [TMR_W-1:0] HUNT_LAST   = TMR_W'(HUNT_TO_CYC - 1);
  localparam logic [TMR_W-1:0] ADV_LAST    = TMR_W'(ADV_TO_CYC - 1);
  localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_HUNT     = 4'd1,
    ST_DETECT   = 4'd2,
    ST_SPEED    = 4'd3,
    ST_SPD_CHG  = 4'd4,
    ST_ADV      = 4'd5,
    ST_ADV_WAIT = 4'd6,
    ST_CONFIG   = 4'd7,
    ST_OPER     = 4'd8,
    ST_OP_RST   = 4'd9,
    ST_LOST     = 4'd10,
    ST_FAIL     = 4'd11
  } state_t;

  state_t             state, state_n;
  logic               reconfig_n, fail_n, at_op_speed, at_op_n, link_up_n;
  logic [SPEED_W-1:0] sel_n, speed_cap, cap_n;
  logic [7:0]         retry_n, retry_inc;
  logic [TMR_W-1:0]   timer, timer_n, tmr_last;
  logic               tmr_run, err;

  assign err        = crc_consec_loss | (unexp_frm_err & ~frame_crc_err);
  assign retry_inc  = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
  assign link_state = state;

  // NOTE: every registered value is updated with <= so all flops see the same pre-edge state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_INIT;
      pll_reconfig  <= 1'b0;
      pll_speed_sel <= '0;
      speed_cap     <= MAX_SPEED;
      retry_cnt     <= 8'd0;
      link_fail     <= 1'b0;
      timer         <= '0;
      at_op_speed   <= 1'b0;
      link_up       <= 1'b0;
    end else begin
      state         <= state_n;
      pll_reconfig  <= reconfig_n;
      pll_speed_sel <= sel_n;
      speed_cap     <= cap_n;
      retry_cnt     <= retry_n;
      link_fail     <= fail_n;
      timer         <= timer_n;
      at_op_speed   <= at_op_n;
      link_up       <= link_up_n;
    end
  end

  // NOTE: all next values get a default first, so no path through the case can infer a latch.
  always_comb begin
    state_n    = state;
    reconfig_n = pll_reconfig;
    sel_n      = pll_speed_sel;
    cap_n      = speed_cap;
    retry_n    = retry_cnt;
    fail_n     = link_fail;
    at_op_n    = at_op_speed;
    tmr_run    = 1'b0;
    tmr_last   = '0;

    case (state)
      ST_INIT: begin
        // pll_done is only honoured once our request is visible, so a stale done is ignored.
        if (pll_reconfig && pll_done) begin
          reconfig_n = 1'b0;
          state_n    = ST_HUNT;
        end else begin
          reconfig_n = 1'b1;
        end
      end
      ST_HUNT: begin
        if (aligned) begin
          state_n = at_op_speed ? ST_ADV : ST_DETECT;
        end else if (at_op_speed) begin
          tmr_run  = 1'b1;
          tmr_last = HUNT_LAST;
          if (timer == HUNT_LAST) begin
            state_n = ST_LOST;
            cap_n   = (speed_cap == '0) ? speed_cap : speed_cap - 1'b1;
          end
        end
      end
      ST_DETECT: begin
        if (err) state_n = ST_LOST;
        else if (((detect_locked && detect_tx_done) || remote_in_speed) && frame_end)
          state_n = ST_SPEED;
      end
      ST_SPEED: begin
        if (err || speed_timeout) begin
          state_n = ST_LOST;
        end else if (speed_tx_done && frame_end) begin
          state_n = ST_SPD_CHG;
          sel_n   = (remote_speed < speed_cap) ? remote_speed : speed_cap;
        end
      end
      ST_SPD_CHG: begin
        if (pll_reconfig && pll_done) begin
          reconfig_n = 1'b0;
          at_op_n    = 1'b1;
          state_n    = ST_HUNT;
        end else begin
          reconfig_n = 1'b1;
        end
      end
      ST_ADV: begin
        tmr_run  = 1'b1;
        tmr_last = ADV_LAST;
        if (err) begin
          state_n = ST_LOST;
        end else if (timer == ADV_LAST) begin
          if (!advertise_locked)      state_n = ST_LOST;
          else if (!auto_move_config) state_n = ST_ADV_WAIT;
          else if (frame_end)         state_n = ST_CONFIG;
        end
      end
      ST_ADV_WAIT: begin
        if (err) state_n = ST_LOST;
        else if (trigger_config && frame_end) state_n = ST_CONFIG;
      end
      ST_CONFIG: begin
        if (err) state_n = ST_LOST;
        else if (cfg_timeout && frame_end) state_n = ST_ADV;
        else if (accept_rcv && frame_end) state_n = ST_OPER;
      end
      ST_OPER: begin
        retry_n = 8'd0;
        if (err) begin
          state_n = ST_LOST;
        end else if (sw_reset || remote_sw_reset) begin
          state_n = ST_OP_RST;
        end else if (retrain_req) begin
          state_n = ST_INIT;
          sel_n   = '0;
          at_op_n = 1'b0;
          cap_n   = MAX_SPEED;
        end else if (op_frm_lost) begin
          state_n = ST_LOST;
        end
      end
      ST_OP_RST: begin
        if (frame_end) state_n = ST_ADV;
      end
      ST_LOST: begin
        retry_n = retry_inc;
        sel_n   = '0;
        at_op_n = 1'b0;
        if (retry_inc == RETRY_LIMIT) begin
          state_n = ST_FAIL;
          fail_n  = 1'b1;
        end else begin
          state_n = ST_INIT;
        end
      end
      ST_FAIL: begin
        reconfig_n = 1'b0;
        if (retrain_req || sw_reset) begin
          fail_n  = 1'b0;
          retry_n = 8'd0;
          cap_n   = MAX_SPEED;
          state_n = ST_INIT;
        end
      end
      default: begin
        state_n    = ST_INIT;
        reconfig_n = 1'b0;
      end
    endcase

    if (state_n != state)                  timer_n = '0;
    else if (tmr_run && timer != tmr_last) timer_n = timer + 1'b1;
    else                                   timer_n = timer;

    link_up_n = (state_n == ST_OPER);
  end

endmodule

// File: tb/tb_mgmt_phy_link_trainer.sv
// Directed bench: two trainers share stimulus; dut_a (MAX_RETRY 8) covers training and
// fallback, dut_b (MAX_RETRY 3) covers retry exhaustion. Each has a one-cycle PLL responder.
module tb_mgmt_phy_link_trainer;

  localparam int S_INIT = 0, S_HUNT = 1, S_SPD_CHG = 4, S_ADV = 5, S_ADV_WAIT = 6,
                 S_CONFIG = 7, S_OPER = 8, S_OP_RST = 9, S_LOST = 10, S_FAIL = 11;

  logic       clk = 1'b0, reset = 1'b1;
  logic       frame_end = 0, aligned = 0, crc_consec_loss = 0, unexp_frm_err = 0;
  logic       frame_crc_err = 0, detect_locked = 0, detect_tx_done = 0, remote_in_speed = 0;
  logic       speed_tx_done = 0, speed_timeout = 0, advertise_locked = 0, auto_move_config = 0;
  logic       trigger_config = 0, cfg_timeout = 0, accept_rcv = 0, op_frm_lost = 0;
  logic       sw_reset = 0, remote_sw_reset = 0, retrain_req = 0;
  logic [3:0] remote_speed = 4'd0;
  logic       pll_done_a, pll_done_b, pll_reconfig_a, pll_reconfig_b;
  logic [3:0] sel_a, sel_b, link_state_a, link_state_b;
  logic [7:0] retry_a, retry_b;
  logic       link_fail_a, link_fail_b, link_up_a, link_up_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pll_done_a <= 1'b0;
      pll_done_b <= 1'b0;
    end else begin
      pll_done_a <= pll_reconfig_a;
      pll_done_b <= pll_reconfig_b;
    end
  end

  mgmt_phy_link_trainer #(.SPEED_W(4), .MAX_SPEED(4'd7), .HUNT_TO_CYC(20), .ADV_TO_CYC(8),
                          .MAX_RETRY(8)) dut_a (
    .clk(clk), .reset(reset), .frame_end(frame_end), .aligned(aligned),
    .crc_consec_loss(crc_consec_loss), .unexp_frm_err(unexp_frm_err),
    .frame_crc_err(frame_crc_err), .detect_locked(detect_locked),
    .detect_tx_done(detect_tx_done), .remote_in_speed(remote_in_speed),
    .speed_tx_done(speed_tx_done), .speed_timeout(speed_timeout),
    .remote_speed(remote_speed), .advertise_locked(advertise_locked),
    .auto_move_config(auto_move_config), .trigger_config(trigger_config),
    .cfg_timeout(cfg_timeout), .accept_rcv(accept_rcv), .op_frm_lost(op_frm_lost),
    .sw_reset(sw_reset), .remote_sw_reset(remote_sw_reset), .retrain_req(retrain_req),
    .pll_done(pll_done_a), .pll_reconfig(pll_reconfig_a), .pll_speed_sel(sel_a),
    .link_state(link_state_a), .retry_cnt(retry_a), .link_fail(link_fail_a),
    .link_up(link_up_a));

  mgmt_phy_link_trainer #(.SPEED_W(4), .MAX_SPEED(4'd7), .HUNT_TO_CYC(20), .ADV_TO_CYC(8),
                          .MAX_RETRY(3)) dut_b (
    .clk(clk), .reset(reset), .frame_end(frame_end), .aligned(aligned),
    .crc_consec_loss(crc_consec_loss), .unexp_frm_err(unexp_frm_err),
    .frame_crc_err(frame_crc_err), .detect_locked(detect_locked),
    .detect_tx_done(detect_tx_done), .remote_in_speed(remote_in_speed),
    .speed_tx_done(speed_tx_done), .speed_timeout(speed_timeout),
    .remote_speed(remote_speed), .advertise_locked(advertise_locked),
    .auto_move_config(auto_move_config), .trigger_config(trigger_config),
    .cfg_timeout(cfg_timeout), .accept_rcv(accept_rcv), .op_frm_lost(op_frm_lost),
    .sw_reset(sw_reset), .remote_sw_reset(remote_sw_reset), .retrain_req(retrain_req),
    .pll_done(pll_done_b), .pll_reconfig(pll_reconfig_b), .pll_speed_sel(sel_b),
    .link_state(link_state_b), .retry_cnt(retry_b), .link_fail(link_fail_b),
    .link_up(link_up_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] st(input bit use_b);
    return use_b ? link_state_b : link_state_a;
  endfunction

  task automatic wait_state(input bit use_b, input int target, input int budget,
                            input string tag);
    int n = 0;
    while (32'(st(use_b)) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(st(use_b)), target);
  endtask

  initial begin
    int cnt;
    step(2);
    check("rst_state", 32'(link_state_a), S_INIT);
    check("rst_reconfig", 32'(pll_reconfig_a), 0);
    check("rst_sel", 32'(sel_a), 0);
    check("rst_retry", 32'(retry_a), 0);
    check("rst_fail", 32'(link_fail_a), 0);
    check("rst_link_up", 32'(link_up_a), 0);
    reset = 1'b0;
    step();
    check("init_req", 32'(pll_reconfig_a), 1);
    // Asynchronous reset in the middle of a PLL request must drop it before any clock edge.
    #2 reset = 1'b1;
    #1 check("rst_mid_pll", 32'(pll_reconfig_a), 0);
    @(negedge clk) reset = 1'b0;

    // Clean bring-up with remote advertising speed 5.
    aligned = 1; detect_locked = 1; detect_tx_done = 1; frame_end = 1; speed_tx_done = 1;
    remote_speed = 4'd5; advertise_locked = 1; auto_move_config = 1;
    wait_state(0, S_CONFIG, 100, "bringup_config");
    check("bringup_sel", 32'(sel_a), 5);
    frame_end = 0; accept_rcv = 1;
    step(5);
    check("gate_config_hold", 32'(link_state_a), S_CONFIG);
    frame_end = 1;
    step();
    check("gate_oper", 32'(link_state_a), S_OPER);
    check("oper_link_up", 32'(link_up_a), 1);
    check("oper_retry", 32'(retry_a), 0);
    accept_rcv = 0;

    // sw_reset outranks op_frm_lost; OP_RST leaves on frame_end.
    sw_reset = 1; op_frm_lost = 1; frame_end = 0;
    step();
    check("oper_prio", 32'(link_state_a), S_OP_RST);
    sw_reset = 0; op_frm_lost = 0; auto_move_config = 0; frame_end = 1;
    step();
    check("oprst_adv", 32'(link_state_a), S_ADV);
    wait_state(0, S_ADV_WAIT, 20, "manual_adv_wait");
    frame_end = 0; trigger_config = 1;
    step(3);
    check("manual_gate", 32'(link_state_a), S_ADV_WAIT);
    frame_end = 1;
    step();
    check("manual_config", 32'(link_state_a), S_CONFIG);
    trigger_config = 0; accept_rcv = 1;
    step();
    check("manual_oper", 32'(link_state_a), S_OPER);
    accept_rcv = 0;

    // frame_crc_err masks unexp_frm_err.
    unexp_frm_err = 1; frame_crc_err = 1;
    step();
    check("crc_mask", 32'(link_state_a), S_OPER);
    unexp_frm_err = 0; frame_crc_err = 0;

    retrain_req = 1;
    step();
    check("retrain_init", 32'(link_state_a), S_INIT);
    check("retrain_sel", 32'(sel_a), 0);
    check("retrain_link_up", 32'(link_up_a), 0);
    retrain_req = 0;
    step();
    check("retrain_pll_req", 32'(pll_reconfig_a), 1);

    // Retry exhaustion: errors in DETECT until dut_b (MAX_RETRY 3) fails.
    crc_consec_loss = 1;
    wait_state(1, S_FAIL, 100, "exhaust_fail");
    crc_consec_loss = 0; remote_speed = 4'd7;
    check("exhaust_link_fail", 32'(link_fail_b), 1);
    check("exhaust_retry", 32'(retry_b), 3);
    check("retry8_not_failed", 32'(link_state_a), S_INIT);
    check("retry8_count", 32'(retry_a), 3);
    check("retry8_link_fail", 32'(link_fail_a), 0);
    step(2);
    check("fail_sticky", 32'(link_state_b), S_FAIL);
    retrain_req = 1;
    step();
    check("fail_clear_state", 32'(link_state_b), S_INIT);
    check("fail_clear_flag", 32'(link_fail_b), 0);
    check("fail_clear_retry", 32'(retry_b), 0);
    retrain_req = 0;

    // Speed fallback on dut_a: remote 7, cap steps 7,6,5,4 after each failed hunt.
    for (int r = 0; r < 4; r++) begin
      wait_state(0, S_SPD_CHG, 60, "fallback_spd_chg");
      check("fallback_sel", 32'(sel_a), 7 - r);
      if (r < 3) begin
        aligned = 0;
        wait_state(0, S_HUNT, 10, "fallback_hunt");
        cnt = 0;
        while (32'(link_state_a) == S_HUNT && cnt < 100) begin
          cnt++;
          step();
        end
        check("hunt_timeout_cycles", cnt, 20);
        check("hunt_lost", 32'(link_state_a), S_LOST);
        step();
        check("lost_init", 32'(link_state_a), S_INIT);
        check("lost_sel", 32'(sel_a), 0);
        check("lost_retry", 32'(retry_a), 4 + r);
        aligned = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
